// File: rtl/cpu_pkg.sv
// Shared branch-prediction types: PC-mux select codes, controller states
// and the PC-to-BHT index mapping.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_PRED = 2'd1,
        PC_FIX  = 2'd2
    } pcsel_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bpu_state_t;

    // Word-aligned PC to BHT index; callers keep the low idx_w bits.
    function automatic logic [31:0] bht_index(input logic [31:0] pc, input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (pc >> 2) & mask;
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Circular queue of pending BHT writes with associative index match and in-place overwrite.
// Latency: an entry is visible to match/head outputs the cycle after it is pushed.
// Backpressure: none internally; the owner must not push a new slot when full without a dequeue.
module bht_upd_fifo #(
    parameter int IDX_W  = 10,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_vld_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_dat_i,
    input  logic             deq_i,
    input  logic [IDX_W-1:0] lk_idx_i,
    output logic             lk_hit_o,
    output logic             lk_dat_o,
    output logic             upd_hit_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [IDX_W-1:0] head_idx_o,
    output logic             head_dat_o
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] idx_q [QDEPTH];
    logic             dat_q [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] upd_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr;
    logic             push;

    // Scan oldest to youngest so the last hit found is the youngest.
    always_comb begin
        lk_hit_o  = 1'b0;
        lk_dat_o  = 1'b0;
        upd_hit_o = 1'b0;
        upd_ptr   = rd_ptr_q;
        for (int k = 0; k < QDEPTH; k++) begin
            if (CNT_W'(k) < cnt_q) begin
                if (idx_q[rd_ptr_q + PTR_W'(k)] == lk_idx_i) begin
                    lk_hit_o = 1'b1;
                    lk_dat_o = dat_q[rd_ptr_q + PTR_W'(k)];
                end
                if (idx_q[rd_ptr_q + PTR_W'(k)] == upd_idx_i) begin
                    upd_hit_o = 1'b1;
                    upd_ptr   = rd_ptr_q + PTR_W'(k);
                end
            end
        end
    end

    // A match on the entry leaving this cycle cannot be overwritten; re-append instead.
    assign ovr  = upd_vld_i && upd_hit_o && !(deq_i && (upd_ptr == rd_ptr_q));
    assign push = upd_vld_i && !ovr;

    assign rd_ptr_d = rd_ptr_q + PTR_W'(deq_i);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(deq_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[wr_ptr_q] <= upd_idx_i;
            dat_q[wr_ptr_q] <= upd_dat_i;
        end else if (ovr) begin
            dat_q[upd_ptr] <= upd_dat_i;
        end
    end

    assign full_o     = (cnt_q == CNT_W'(QDEPTH));
    assign empty_o    = (cnt_q == '0);
    assign head_idx_o = idx_q[rd_ptr_q];
    assign head_dat_o = dat_q[rd_ptr_q];

endmodule

// File: rtl/bpu_ctrl.sv
// BHT sequencing controller: ID lookups to PC select, ME resolutions to redirect/flush, queued BHT writes.
// Latency: prediction and redirect are combinational; one RECOVER cycle follows each redirect.
// Backpressure: raises stallIf when a resolution needs a queue slot and the queue is full.
module bpu_ctrl
    import cpu_pkg::*;
#(
    parameter int IDX_W  = 10,
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idBranch,
    input  logic [31:0]      idPc,
    input  logic             meBranch,
    input  logic [31:0]      mePc,
    input  logic             meTaken,
    input  logic             mePredTaken,
    input  logic [31:0]      meTarget,
    input  logic             bhtRdata,
    output logic             bhtRen,
    output logic             bhtWen,
    output logic [IDX_W-1:0] bhtIdx,
    output logic             bhtWdata,
    output logic             predTaken,
    output logic [1:0]       pcSel,
    output logic [31:0]      correctPc,
    output logic             flushIfId,
    output logic             flushIdEx,
    output logic             flushExMe,
    output logic             stallIf,
    output logic [CNT_W-1:0] brCount,
    output logic [CNT_W-1:0] missCount
);
    bpu_state_t       state_q, state_d;
    logic [31:0]      correct_q, correct_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [31:0]      id_idx_w, me_idx_w, fix_pc;
    logic [IDX_W-1:0] id_idx, me_idx, head_idx;
    logic             unused_idx_hi;
    logic             mispred, in_recover, redirect, stall, lookup, deq, pred;
    logic             byp_hit, byp_dat, upd_hit, q_full, q_empty, head_dat;
    pcsel_t           sel;

    assign id_idx_w      = bht_index(idPc, IDX_W);
    assign me_idx_w      = bht_index(mePc, IDX_W);
    assign id_idx        = id_idx_w[IDX_W-1:0];
    assign me_idx        = me_idx_w[IDX_W-1:0];
    assign unused_idx_hi = ^{id_idx_w[31:IDX_W], me_idx_w[31:IDX_W]};

    assign mispred    = meBranch && (meTaken != mePredTaken);
    assign fix_pc     = meTaken ? meTarget : (mePc + 32'd4);
    assign in_recover = (state_q == RECOVER);

    // Priority in RUN: redirect, then full-queue stall, then lookup.
    always_comb begin
        state_d   = state_q;
        correct_d = correct_q;
        redirect  = 1'b0;
        stall     = 1'b0;
        lookup    = 1'b0;
        if (in_recover) begin
            state_d = RUN;
        end else if (mispred) begin
            redirect  = 1'b1;
            correct_d = fix_pc;
            state_d   = RECOVER;
        end else if (meBranch && q_full && !upd_hit) begin
            stall = 1'b1;
        end else if (idBranch) begin
            lookup = 1'b1;
        end
    end

    assign deq  = !lookup && !q_empty;
    assign pred = lookup && (byp_hit ? byp_dat : bhtRdata);

    always_comb begin
        sel = PC_SEQ;
        if (redirect) begin
            sel = PC_FIX;
        end else if (pred) begin
            sel = PC_PRED;
        end
    end

    assign br_cnt_d   = (meBranch && !(&br_cnt_q))  ? br_cnt_q + CNT_W'(1)   : br_cnt_q;
    assign miss_cnt_d = (mispred  && !(&miss_cnt_q)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            correct_q  <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            correct_q  <= correct_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    bht_upd_fifo #(
        .IDX_W  (IDX_W),
        .QDEPTH (QDEPTH)
    ) u_upd_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_vld_i  (meBranch),
        .upd_idx_i  (me_idx),
        .upd_dat_i  (meTaken),
        .deq_i      (deq),
        .lk_idx_i   (id_idx),
        .lk_hit_o   (byp_hit),
        .lk_dat_o   (byp_dat),
        .upd_hit_o  (upd_hit),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .head_idx_o (head_idx),
        .head_dat_o (head_dat)
    );

    // Combinational outputs are forced low while reset is asserted.
    assign bhtRen    = rst_n && lookup;
    assign bhtWen    = rst_n && deq;
    assign bhtIdx    = !rst_n ? '0 : (lookup ? id_idx : (deq ? head_idx : '0));
    assign bhtWdata  = rst_n && deq && head_dat;
    assign predTaken = rst_n && pred;
    assign pcSel     = rst_n ? sel : PC_SEQ;
    assign correctPc = !rst_n ? 32'd0 : (redirect ? fix_pc : correct_q);
    assign flushIfId = rst_n && (redirect || in_recover);
    assign flushIdEx = rst_n && redirect;
    assign flushExMe = rst_n && redirect;
    assign stallIf   = rst_n && stall;
    assign brCount   = br_cnt_q;
    assign missCount = miss_cnt_q;

endmodule

// File: tb/tb_bpu_ctrl.sv
// Randomized scoreboard bench for bpu_ctrl: a per-cycle reference model pushes
// expected outputs; a negedge monitor pops and compares.
module tb_bpu_ctrl;
    localparam int IDX_W  = 10;
    localparam int QDEPTH = 4;
    localparam int CNT_W  = 16;

    logic             clk;
    logic             rst_n;
    logic             idBranch, meBranch, meTaken, mePredTaken;
    logic [31:0]      idPc, mePc, meTarget;
    logic             bhtRdata;
    logic             bhtRen, bhtWen, bhtWdata, predTaken;
    logic [IDX_W-1:0] bhtIdx;
    logic [1:0]       pcSel;
    logic [31:0]      correctPc;
    logic             flushIfId, flushIdEx, flushExMe, stallIf;
    logic [CNT_W-1:0] brCount, missCount;

    bpu_ctrl #(.IDX_W(IDX_W), .QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .idBranch(idBranch), .idPc(idPc),
        .meBranch(meBranch), .mePc(mePc), .meTaken(meTaken),
        .mePredTaken(mePredTaken), .meTarget(meTarget),
        .bhtRdata(bhtRdata), .bhtRen(bhtRen), .bhtWen(bhtWen),
        .bhtIdx(bhtIdx), .bhtWdata(bhtWdata), .predTaken(predTaken),
        .pcSel(pcSel), .correctPc(correctPc),
        .flushIfId(flushIfId), .flushIdEx(flushIdEx), .flushExMe(flushExMe),
        .stallIf(stallIf), .brCount(brCount), .missCount(missCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BHT storage: seeded contents overlaid by writes from the DUT.
    bit seed     [1024];
    bit wr_seen  [1024];
    bit wr_val   [1024];
    assign bhtRdata = wr_seen[bhtIdx] ? wr_val[bhtIdx] : seed[bhtIdx];
    always @(posedge clk) begin
        if (bhtWen) begin
            wr_seen[bhtIdx] <= 1'b1;
            wr_val[bhtIdx]  <= bhtWdata;
        end
    end

    typedef struct packed {
        logic             ren;
        logic             wen;
        logic [IDX_W-1:0] idx;
        logic             wdat;
        logic             pred;
        logic [1:0]       sel;
        logic [31:0]      cpc;
        logic             fi, fd, fe, stall;
        logic [CNT_W-1:0] br, miss;
    } exp_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             dat;
    } ent_t;

    exp_t        expq[$];
    ent_t        pend[$];
    bit          last_dir [1024];
    bit          m_rec;
    logic [31:0] m_fix;
    int          m_br, m_miss;
    int          n_chk, n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Reference: prediction = most recent resolved direction; pending writes kept as an ordered list.
    task automatic model_step();
        exp_t             e;
        bit               mis, stall, lookup, wr;
        int               pos;
        logic [31:0]      fix;
        logic [IDX_W-1:0] ii, mi;
        e   = '0;
        ii  = idPc[11:2];
        mi  = mePc[11:2];
        mis = meBranch && (meTaken != mePredTaken);
        fix = meTaken ? meTarget : mePc + 32'd4;
        pos = -1;
        for (int i = 0; i < pend.size(); i++) if (pend[i].idx == mi) pos = i;
        stall  = 0;
        lookup = 0;
        if (m_rec) begin
            e.fi = 1;
        end else if (mis) begin
            e.sel = 2; e.fi = 1; e.fd = 1; e.fe = 1;
        end else if (meBranch && pend.size() == QDEPTH && pos < 0) begin
            stall = 1;
        end else if (idBranch) begin
            lookup = 1;
        end
        e.cpc   = (!m_rec && mis) ? fix : m_fix;
        e.stall = stall;
        wr      = !lookup && pend.size() > 0;
        if (lookup) begin
            e.ren  = 1;
            e.idx  = ii;
            e.pred = last_dir[ii];
            e.sel  = e.pred ? 2'd1 : 2'd0;
        end else if (wr) begin
            e.wen  = 1;
            e.idx  = pend[0].idx;
            e.wdat = pend[0].dat;
        end
        e.br   = CNT_W'(m_br);
        e.miss = CNT_W'(m_miss);
        expq.push_back(e);
        if (wr) void'(pend.pop_front());
        if (meBranch) begin
            pos = -1;
            for (int i = 0; i < pend.size(); i++) if (pend[i].idx == mi) pos = i;
            if (pos >= 0) pend[pos].dat = meTaken;
            else pend.push_back('{idx: mi, dat: meTaken});
            last_dir[mi] = meTaken;
            if (m_br < 65535) m_br++;
            if (mis && m_miss < 65535) m_miss++;
        end
        if (!m_rec && mis) begin
            m_fix = fix;
            m_rec = 1;
        end else begin
            m_rec = 0;
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_rec  = 0;
        m_fix  = '0;
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic drive(input bit idb, input logic [31:0] idp, input bit meb,
                         input logic [31:0] mep, input bit mt, input bit mpt,
                         input logic [31:0] tgt);
        @(posedge clk);
        #1;
        idBranch = idb; idPc = idp; meBranch = meb; mePc = mep;
        meTaken = mt; mePredTaken = mpt; meTarget = tgt;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idBranch = 1; idPc = 32'h40; meBranch = 1; mePc = 32'h40;
        meTaken = 1; mePredTaken = 0; meTarget = 32'h1234;
        expq.push_back('0);
    endtask

    function automatic logic [31:0] rand_pc();
        return ($urandom & 32'hFFFF_F000) | (32'($urandom_range(16, 23)) << 2);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("bhtRen",    32'(bhtRen),    32'(e.ren));
            chk("bhtWen",    32'(bhtWen),    32'(e.wen));
            chk("bhtIdx",    32'(bhtIdx),    32'(e.idx));
            chk("bhtWdata",  32'(bhtWdata),  32'(e.wdat));
            chk("predTaken", 32'(predTaken), 32'(e.pred));
            chk("pcSel",     32'(pcSel),     32'(e.sel));
            chk("correctPc", correctPc,      e.cpc);
            chk("flushIfId", 32'(flushIfId), 32'(e.fi));
            chk("flushIdEx", 32'(flushIdEx), 32'(e.fd));
            chk("flushExMe", 32'(flushExMe), 32'(e.fe));
            chk("stallIf",   32'(stallIf),   32'(e.stall));
            chk("brCount",   32'(brCount),   32'(e.br));
            chk("missCount", 32'(missCount), 32'(e.miss));
        end
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) seed[i] = 1'($urandom_range(0, 1));
        seed[16] = 1'b1;
        for (int i = 0; i < 1024; i++) last_dir[i] = seed[i];
        model_reset();
        rst_n = 1'b0;
        idBranch = 1; idPc = 32'h40; meBranch = 1; mePc = 32'h40;
        meTaken = 1; mePredTaken = 0; meTarget = 32'h1234;
        repeat (3) begin
            @(posedge clk);
            #1;
            expq.push_back('0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idBranch = 0; meBranch = 0;
        model_step();

        // Lookup hit on a seeded taken entry.
        drive(1, 32'h40, 0, 32'h0, 0, 0, 32'h0);
        // Not-taken mispredict racing an ID lookup; the redirect wins.
        drive(1, 32'h40, 1, 32'h40, 0, 1, 32'h100);
        drive(1, 32'h40, 0, 32'h0, 0, 0, 32'h0);
        drive(1, 32'h40, 0, 32'h0, 0, 0, 32'h0);
        // Taken mispredict, then the drain in the RECOVER cycle.
        drive(0, 32'h0, 1, 32'h40, 1, 0, 32'h100);
        drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        // Bypass: queued not-taken must override BHT data on the next lookup.
        drive(1, 32'h44, 1, 32'h40, 0, 0, 32'h0);
        drive(1, 32'h40, 0, 32'h0, 0, 0, 32'h0);
        idle(1);
        // Queue fill under continuous lookups, then overwrite and mispredict at full.
        for (int i = 0; i < 5; i++)
            drive(1, 32'h80, 1, 32'hC0 + 32'(i * 4), 1, 1, 32'h0);
        drive(1, 32'h80, 1, 32'hC4, 0, 0, 32'h0);
        drive(1, 32'h80, 1, 32'hE0, 1, 0, 32'h200);
        drive(1, 32'h80, 0, 32'h0, 0, 0, 32'h0);
        idle(5);
        // Fall-through address wraps past the top of the address space.
        drive(0, 32'h0, 1, 32'hFFFF_FFFC, 0, 1, 32'h0);
        idle(2);

        for (int c = 0; c < 400; c++) begin
            bit idb, meb, mt, mpt;
            idb = ($urandom_range(0, 9) < 7);
            meb = !m_rec && ($urandom_range(0, 9) < 6);
            mt  = 1'($urandom_range(0, 1));
            mpt = ($urandom_range(0, 9) < 2) ? !mt : mt;
            drive(idb, rand_pc(), meb, rand_pc(), mt, mpt, $urandom);
        end
        idle(QDEPTH + 2);
        @(negedge clk);
        #1;
        for (int i = 0; i < 1024; i++)
            chk("bht_final", 32'(wr_seen[i] ? wr_val[i] : seed[i]), 32'(last_dir[i]));

        // Reset during RECOVER with three writes pending.
        for (int i = 0; i < 3; i++)
            drive(1, 32'h80, 1, 32'h100 + 32'(i * 4), 0, 0, 32'h0);
        drive(1, 32'h80, 1, 32'h10C, 1, 0, 32'h300);
        reset_cycle();
        reset_cycle();
        reset_cycle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idBranch = 0; meBranch = 0;
        model_reset();
        model_step();
        idle(4);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bpu_ctrl.md
# bpu_ctrl

Sequencing controller for the 1-bit branch history table (BHT) in the pipelined CPU. It turns ID-stage lookups into PC-select decisions and ME-stage resolutions into misprediction recovery (redirect plus flushes). It serializes BHT writes through a 4-entry update queue, because the BHT has one shared read/write port. It sits between the hazard unit, the PC mux and the BHT storage.

## Interface
- `IDX_W`, 10: BHT index width; index = pc[IDX_W+1:2].
- `QDEPTH`, 4: update-queue depth; power of two.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `idBranch` in 1: ID stage holds a conditional branch that needs a prediction.
- `idPc` in 32: PC of the ID-stage instruction.
- `meBranch` in 1: a branch resolves in ME this cycle.
- `mePc` in 32: PC of the resolving branch.
- `meTaken` in 1: actual direction of the resolving branch.
- `mePredTaken` in 1: the prediction that was carried down the pipe with this branch.
- `meTarget` in 32: branch target address.
- `bhtRdata` in 1: BHT read data for `bhtIdx`, combinational.
- `bhtRen` out 1: BHT read enable.
- `bhtWen` out 1: BHT write enable.
- `bhtIdx` out IDX_W: shared BHT address.
- `bhtWdata` out 1: BHT write data.
- `predTaken` out 1: prediction for the ID branch; 0 when `idBranch`=0.
- `pcSel` out 2: PC mux select. 0 = pc+4, 1 = predicted target, 2 = `correctPc`.
- `correctPc` out 32: recovery PC.
- `flushIfId`, `flushIdEx`, `flushExMe` out 1 each: pipeline-register flushes.
- `stallIf` out 1: freeze PC and IF/ID.
- `brCount`, `missCount` out CNT_W each: saturating statistics counters.

## Operation
- States: RUN, RECOVER.
- Misprediction: `meBranch` && (`meTaken` != `mePredTaken`).
- `correctPc`: `meTarget` if `meTaken`, else `mePc`+4.

In RUN, each cycle:
- Mispredict present:
  - combinationally, `pcSel`=2 and all three flushes=1;
  - `correctPc` latched;
  - next state RECOVER.
- Otherwise, if `idBranch` and the port is granted to the read:
  - `bhtRen`=1, `bhtIdx`=idPc index;
  - `predTaken` = bypassed data if the index matches a queued entry (youngest match wins), else `bhtRdata`;
  - `pcSel` = `predTaken` ? 1 : 0.

In RECOVER (exactly 1 cycle):
- `pcSel`=0 and no lookup (ID holds a bubble);
- `flushIfId`=1;
- the queue drains one entry;
- returns to RUN.

Update queue:
- Every `meBranch` enqueues {index(mePc), `meTaken`}, mispredicted or not.
- If the incoming index equals a queued entry, that entry's data is overwritten in place and nothing new is enqueued.

Port arbitration:
- The lookup has priority; the queue head is written when there is no lookup that cycle.
- Queue full and `meBranch` needs a new slot: `stallIf`=1 and the lookup is suppressed that cycle. The head writes and the new entry enqueues in the same cycle (simultaneous dequeue and enqueue is legal).
- Queue empty: `bhtWen`=0.

Counters:
- `brCount` increments on every `meBranch`.
- `missCount` increments on every misprediction.
- Both saturate at all-ones.

## Timing
Reset (async assert, sync-clean release):
- state=RUN, queue empty (pointers 0, count 0), counters 0, `correctPc`=0.
- All outputs 0 while `rst_n`=0.
- Reset mid-RECOVER or with a non-empty queue discards the pending writes. The BHT contents themselves are not reset by this block.

Latencies:
- Prediction: 0 cycles, combinational from `idBranch`/`bhtRdata`.
- Redirect: 0 cycles in the detection cycle, then 1 RECOVER cycle.
- Misprediction penalty: 3 flushed slots plus 1 bubble.
- A queued write is visible to the bypass in the cycle after enqueue.
- The write reaches the BHT no earlier than 1 cycle after enqueue.

Width and wrap:
- Queue pointers are log2(QDEPTH) bits and wrap modulo QDEPTH; count is log2(QDEPTH)+1 bits.
- `mePc`+4 wraps modulo 2^32.

Boundary cases:
- Mispredict and `idBranch` in the same cycle: the mispredict wins; no lookup and no stall.
- Mispredict while the queue is full: the redirect still happens in the same cycle and the head write proceeds; `stallIf` is not asserted, because the flush supersedes it.

## Structure
- Shared package `cpu_pkg`:
  - `pcsel_t` constants PC_SEQ=0, PC_PRED=1, PC_FIX=2;
  - state encoding RUN/RECOVER;
  - the BHT index-extraction function.
- One sub-module, `bht_upd_fifo`: QDEPTH-entry circular queue with an associative index match. It outputs a hit flag plus the youngest matching data, and supports in-place overwrite.
- The controller FSM, arbitration and counters live in `bpu_ctrl`.

## Test plan
- Reset, then `idBranch`=1, `idPc`=0x40, `bhtRdata`=1 -> `bhtIdx`=0x10, `predTaken`=1, `pcSel`=1, no flushes.
- `meBranch` with `mePc`=0x40, `meTaken`=0, `mePredTaken`=1 -> same cycle `pcSel`=2, `correctPc`=0x44, three flushes. Next cycle: RECOVER, `flushIfId`=1. `missCount`=1.
- Taken mispredict with `meTarget`=0x100 -> `correctPc`=0x100. The queued write {0x10,1} appears on `bhtWen`/`bhtWdata` in the first lookup-free cycle.
- Bypass: enqueue {0x10,0}, then next cycle `idBranch` at 0x40 with `bhtRdata`=1 -> `predTaken`=0.
- Queue fill: continuous `idBranch` plus 5 correctly predicted `meBranch` at distinct indices -> `stallIf`=1 on the 5th, one write drains, count stays 4. Same-index updates cause no stall (overwrite).
- Assert `rst_n`=0 mid-RECOVER with 3 entries queued -> outputs 0 immediately. After release: RUN, no `bhtWen`, counters 0.
